// File: rtl/mandelbrot_sequencer.sv
// rtl/mandelbrot_sequencer.sv - frame controller, nibble gather and pixel FIFO for the mandelbrot core
// The pixel FIFO occupancy includes the registered output slot, so FIFO_DEPTH bounds the total held.
module mandelbrot_sequencer #(
  parameter int CTRWIDTH   = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [CTRWIDTH-1:0] max_iter,
  output logic                busy,
  output logic                frame_done,
  output logic                overflow,
  output logic [15:0]         pix_count,
  output logic                core_run,
  output logic [CTRWIDTH-1:0] core_max_ctr,
  output logic [1:0]          core_ctr_select,
  input  logic                core_running,
  input  logic [3:0]          core_ctr_out,
  input  logic                core_new_ctr,
  output logic [CTRWIDTH-1:0] pix_data,
  output logic                pix_valid,
  input  logic                pix_ready
);

  localparam int NNIB = (CTRWIDTH + 3) / 4;
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_core_run;
  logic                  r_frame_done;
  logic [CTRWIDTH-1:0]   r_core_max_ctr;

  logic                  r_gathering;
  logic                  r_push_pend;
  logic [1:0]            r_sel;
  logic [CTRWIDTH-1:0]   r_acc;

  logic [CTRWIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_pix_valid;
  logic [CTRWIDTH-1:0]   r_pix_data;
  logic                  r_overflow;
  logic [15:0]           r_pix_count;

  logic                  w_active;
  logic                  w_abort;
  logic                  w_start;
  logic                  w_gather_busy;
  logic                  w_gather_idle;
  logic                  w_accept;
  logic                  w_drop_pulse;
  logic                  w_push_req;
  logic [CW-1:0]         w_total;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_load;

  assign w_active      = (r_state == S_LAUNCH) || (r_state == S_RUN);
  assign w_abort       = w_active && abort;
  assign w_start       = (r_state == S_IDLE) && start;
  assign w_gather_busy = r_gathering || r_push_pend;
  assign w_gather_idle = !w_gather_busy && !core_new_ctr;
  assign w_accept      = w_active && !abort && core_new_ctr && !w_gather_busy;
  assign w_drop_pulse  = w_active && !abort && core_new_ctr && w_gather_busy;
  // An abort discards a gathered pixel that has not yet reached the FIFO.
  assign w_push_req    = r_push_pend && !w_abort;
  assign w_total       = r_count + {{AW{1'b0}}, r_pix_valid};
  assign w_full        = (w_total == CW'(FIFO_DEPTH));
  assign w_empty       = (w_total == '0);
  assign w_push        = w_push_req && !w_full;
  assign w_pop         = r_pix_valid && pix_ready;
  assign w_load        = (r_count != '0) && (!r_pix_valid || pix_ready);

  assign busy            = r_busy;
  assign frame_done      = r_frame_done;
  assign core_run        = r_core_run;
  assign core_max_ctr    = r_core_max_ctr;
  assign core_ctr_select = r_sel;
  assign overflow        = r_overflow;
  assign pix_count       = r_pix_count;
  assign pix_valid       = r_pix_valid;
  assign pix_data        = r_pix_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_busy         <= 1'b0;
      r_core_run     <= 1'b0;
      r_frame_done   <= 1'b0;
      r_core_max_ctr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_core_max_ctr <= max_iter;
            r_busy         <= 1'b1;
            r_core_run     <= 1'b1;
            r_state        <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (abort) begin
            r_core_run <= 1'b0;
            r_state    <= S_DRAIN;
          end else if (core_running) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort || (!core_running && w_gather_idle)) begin
            r_core_run <= 1'b0;
            r_state    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_empty) begin
            r_frame_done <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          r_frame_done <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Nibble 0 is captured on the pulse itself because the select idles at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gathering <= 1'b0;
      r_push_pend <= 1'b0;
      r_sel       <= 2'd0;
      r_acc       <= '0;
    end else begin
      r_push_pend <= 1'b0;
      if (!w_active || abort) begin
        r_gathering <= 1'b0;
        r_sel       <= 2'd0;
      end else if (w_accept || r_gathering) begin
        for (int b = 0; b < CTRWIDTH; b++) begin
          if (r_sel == 2'(b / 4)) r_acc[b] <= core_ctr_out[b % 4];
        end
        if (r_sel == 2'(NNIB - 1)) begin
          r_gathering <= 1'b0;
          r_sel       <= 2'd0;
          r_push_pend <= 1'b1;
        end else begin
          r_gathering <= 1'b1;
          r_sel       <= r_sel + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
      r_overflow  <= 1'b0;
      r_pix_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_pix_data  <= r_mem[r_rd_ptr];
        r_pix_valid <= 1'b1;
      end else if (w_pop) begin
        r_pix_valid <= 1'b0;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_load);

      if (w_start) begin
        r_overflow  <= 1'b0;
        r_pix_count <= '0;
      end else begin
        if (w_drop_pulse || (w_push_req && w_full)) r_overflow <= 1'b1;
        if (w_push && (r_pix_count != 16'hFFFF)) r_pix_count <= r_pix_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mandelbrot_sequencer.sv
// tb/tb_mandelbrot_sequencer.sv - directed self-checking bench for mandelbrot_sequencer
module tb_mandelbrot_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [6:0]  max_iter;
  logic        busy;
  logic        frame_done;
  logic        overflow;
  logic [15:0] pix_count;
  logic        core_run;
  logic [6:0]  core_max_ctr;
  logic [1:0]  core_ctr_select;
  logic        core_running;
  logic [3:0]  core_ctr_out;
  logic        core_new_ctr;
  logic [6:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;

  logic [15:0] core_val;
  logic [6:0]  rx_q [$];
  int          done_cnt;
  int          checks;
  int          errors;

  assign core_ctr_out = core_val[{core_ctr_select, 2'b00} +: 4];

  mandelbrot_sequencer #(.CTRWIDTH(7), .FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .max_iter        (max_iter),
    .busy            (busy),
    .frame_done      (frame_done),
    .overflow        (overflow),
    .pix_count       (pix_count),
    .core_run        (core_run),
    .core_max_ctr    (core_max_ctr),
    .core_ctr_select (core_ctr_select),
    .core_running    (core_running),
    .core_ctr_out    (core_ctr_out),
    .core_new_ctr    (core_new_ctr),
    .pix_data        (pix_data),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && pix_valid && pix_ready) rx_q.push_back(pix_data);
    if (frame_done) done_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic emit(input logic [15:0] val, input int gap);
    core_val     = val;
    core_new_ctr = 1'b1;
    tick;
    core_new_ctr = 1'b0;
    repeat (gap - 1) tick;
  endtask

  task automatic start_frame(input logic [6:0] mi);
    max_iter = mi;
    start    = 1'b1;
    tick;
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 200) begin
      tick;
      n++;
    end
    chk(tag, frame_done, 1);
  endtask

  initial begin
    checks = 0; errors = 0; done_cnt = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; max_iter = '0;
    core_running = 1'b0; core_new_ctr = 1'b0; core_val = '0; pix_ready = 1'b0;
    repeat (3) tick;
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_pix_count", pix_count, 0);
    chk("rst_core_run", core_run, 0);
    chk("rst_max_ctr", core_max_ctr, 0);
    chk("rst_select", core_ctr_select, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    rst_n = 1'b1;
    tick;

    // normal frame
    start_frame(7'd100);
    chk("n_busy", busy, 1);
    chk("n_core_run", core_run, 1);
    chk("n_max_ctr", core_max_ctr, 100);
    core_running = 1'b1;
    tick;
    pix_ready = 1'b1;
    rx_q.delete();
    done_cnt = 0;
    core_val = 16'd5; core_new_ctr = 1'b1;
    tick;
    core_new_ctr = 1'b0;
    chk("n_sel_m1", core_ctr_select, 1);
    tick;
    chk("n_sel_m2", core_ctr_select, 0);
    chk("n_valid_m2", pix_valid, 0);
    tick;
    chk("n_valid_m3", pix_valid, 0);
    chk("n_count_m3", pix_count, 1);
    tick;
    chk("n_valid_m4", pix_valid, 1);
    chk("n_data_m4", pix_data, 5);
    emit(16'd100, 4);
    emit(16'h4A, 4);
    repeat (6) tick;
    core_running = 1'b0;
    wait_done("n_done");
    chk("n_busy_done", busy, 1);
    chk("n_pix_count", pix_count, 3);
    chk("n_overflow", overflow, 0);
    chk("n_rx_n", rx_q.size(), 3);
    chk("n_rx0", rx_q[0], 5);
    chk("n_rx1", rx_q[1], 100);
    chk("n_rx2", rx_q[2], 7'h4A);
    tick;
    chk("n_busy_fall", busy, 0);
    chk("n_done_pulse", frame_done, 0);
    chk("n_done_cnt", done_cnt, 1);

    // backpressure
    pix_ready = 1'b0;
    rx_q.delete();
    start_frame(7'd50);
    core_running = 1'b1;
    tick;
    for (int i = 1; i <= 6; i++) emit(16'(i), 4);
    repeat (4) tick;
    chk("b_overflow", overflow, 1);
    chk("b_pix_count", pix_count, 4);
    chk("b_valid", pix_valid, 1);
    chk("b_data", pix_data, 1);
    core_running = 1'b0;
    repeat (3) tick;
    chk("b_core_run", core_run, 0);
    chk("b_held", frame_done, 0);
    chk("b_busy", busy, 1);
    pix_ready = 1'b1;
    wait_done("b_done");
    chk("b_rx_n", rx_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("b_rx", rx_q[i], 32'(i + 1));
    tick;

    // restart after overflow, then gap violation
    start_frame(7'd77);
    chk("r_overflow", overflow, 0);
    chk("r_pix_count", pix_count, 0);
    chk("r_max_ctr", core_max_ctr, 77);
    core_running = 1'b1;
    tick;
    rx_q.delete();
    core_val = 16'h21; core_new_ctr = 1'b1;
    tick;
    tick;
    core_new_ctr = 1'b0;
    chk("g_overflow", overflow, 1);
    repeat (5) tick;
    chk("g_pix_count", pix_count, 1);
    core_running = 1'b0;
    wait_done("g_done");
    chk("g_rx_n", rx_q.size(), 1);
    chk("g_rx0", rx_q[0], 7'h21);
    tick;

    // abort mid-gather with two pixels buffered
    pix_ready = 1'b0;
    rx_q.delete();
    start_frame(7'd90);
    core_running = 1'b1;
    tick;
    emit(16'h11, 4);
    emit(16'h22, 4);
    repeat (2) tick;
    chk("a_pix_count_pre", pix_count, 2);
    core_val = 16'h33; core_new_ctr = 1'b1;
    tick;
    core_new_ctr = 1'b0;
    chk("a_sel_mid", core_ctr_select, 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    core_running = 1'b0;
    chk("a_core_run", core_run, 0);
    chk("a_sel", core_ctr_select, 0);
    chk("a_busy", busy, 1);
    pix_ready = 1'b1;
    wait_done("a_done");
    chk("a_rx_n", rx_q.size(), 2);
    chk("a_rx0", rx_q[0], 7'h11);
    chk("a_rx1", rx_q[1], 7'h22);
    chk("a_pix_count", pix_count, 2);
    chk("a_overflow", overflow, 0);
    tick;

    // asynchronous reset mid-RUN with two pixels buffered
    pix_ready = 1'b0;
    start_frame(7'd20);
    core_running = 1'b1;
    tick;
    emit(16'd7, 4);
    emit(16'd8, 4);
    tick;
    chk("x_valid_pre", pix_valid, 1);
    chk("x_count_pre", pix_count, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("x_busy", busy, 0);
    chk("x_core_run", core_run, 0);
    chk("x_valid", pix_valid, 0);
    chk("x_data", pix_data, 0);
    chk("x_pix_count", pix_count, 0);
    chk("x_max_ctr", core_max_ctr, 0);
    chk("x_select", core_ctr_select, 0);
    chk("x_overflow", overflow, 0);
    core_running = 1'b0;
    tick;
    rst_n = 1'b1;
    pix_ready = 1'b1;
    repeat (3) tick;
    chk("x_flushed", pix_valid, 0);
    chk("x_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
